// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and EX forward selects.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FREEZE  = 2'd2
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // The instruction one stage ahead (EX) is the youngest producer, so it wins over MEM.
    function automatic fwd_sel_e pick_fwd(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return FWD_MEM;
        if (mem_hit)
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Control bundle between the RV32I pipeline datapath (master) and hazard_ctrl (slave).
interface hazard_ctrl_if #(
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 32
);
    logic [RA_W-1:0]  id_rs1_addr;
    logic [RA_W-1:0]  id_rs2_addr;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [RA_W-1:0]  id_rd_addr;
    logic             id_rf_wen;
    logic             id_is_load;
    logic             ex_redirect;
    logic             mem_busy;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             pipe_en;
    logic             id_rs1_byp;
    logic             id_rs2_byp;
    logic [1:0]       fwd_rs1_sel;
    logic [1:0]       fwd_rs2_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_rf_wen, id_is_load, ex_redirect, mem_busy,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, pipe_en,
               id_rs1_byp, id_rs2_byp, fwd_rs1_sel, fwd_rs2_sel,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_rf_wen, id_is_load, ex_redirect, mem_busy,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, pipe_en,
               id_rs1_byp, id_rs2_byp, fwd_rs1_sel, fwd_rs2_sel,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot {valid,rd,wen,load} plus its compare against both ID sources.
module hazard_sb_entry
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            d_valid,
    input  logic [RA_W-1:0] d_rd,
    input  logic            d_wen,
    input  logic            d_load,
    input  logic [RA_W-1:0] src1,
    input  logic            used1,
    input  logic [RA_W-1:0] src2,
    input  logic            used2,
    output logic            q_valid,
    output logic [RA_W-1:0] q_rd,
    output logic            q_wen,
    output logic            q_load,
    output logic            match1,
    output logic            match2
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_rd    <= '0;
            q_wen   <= 1'b0;
            q_load  <= 1'b0;
        end else if (en) begin
            q_valid <= d_valid;
            q_rd    <= d_rd;
            q_wen   <= d_wen;
            q_load  <= d_load;
        end
    end

    // x0 is hardwired zero and never produces a hazard.
    assign match1 = q_valid & q_wen & (q_rd != '0) & (q_rd == src1) & used1;
    assign match2 = q_valid & q_wen & (q_rd != '0) & (q_rd == src2) & used2;

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage RV32I pipeline controller: load-use stall, redirect flush, memory freeze,
// EX forwarding selects and ID regfile bypass driven by an EX/MEM/WB scoreboard.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    hz_state_e        state;
    fwd_sel_e         fwd1_q, fwd2_q;
    logic [CNT_W-1:0] stall_q, flush_q;

    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, pipe_en;
    logic run_like, load_use, redirect_take;

    logic            ex_v, ex_wen, ex_ld, ex_m1, ex_m2;
    logic            mem_v, mem_wen, mem_ld, mem_m1, mem_m2;
    logic            wb_v, wb_wen, wb_ld, wb_m1, wb_m2;
    logic [RA_W-1:0] ex_rd, mem_rd, wb_rd;
    logic            unused_wb;

    hazard_sb_entry #(.RA_W(RA_W)) u_sb_ex (
        .clk(clk), .reset(reset), .en(id_ex_en),
        .d_valid(~id_ex_flush), .d_rd(hz.id_rd_addr),
        .d_wen(hz.id_rf_wen & ~id_ex_flush), .d_load(hz.id_is_load & ~id_ex_flush),
        .src1(hz.id_rs1_addr), .used1(hz.id_rs1_used),
        .src2(hz.id_rs2_addr), .used2(hz.id_rs2_used),
        .q_valid(ex_v), .q_rd(ex_rd), .q_wen(ex_wen), .q_load(ex_ld),
        .match1(ex_m1), .match2(ex_m2)
    );

    hazard_sb_entry #(.RA_W(RA_W)) u_sb_mem (
        .clk(clk), .reset(reset), .en(pipe_en),
        .d_valid(ex_v), .d_rd(ex_rd), .d_wen(ex_wen), .d_load(ex_ld),
        .src1(hz.id_rs1_addr), .used1(hz.id_rs1_used),
        .src2(hz.id_rs2_addr), .used2(hz.id_rs2_used),
        .q_valid(mem_v), .q_rd(mem_rd), .q_wen(mem_wen), .q_load(mem_ld),
        .match1(mem_m1), .match2(mem_m2)
    );

    hazard_sb_entry #(.RA_W(RA_W)) u_sb_wb (
        .clk(clk), .reset(reset), .en(pipe_en),
        .d_valid(mem_v), .d_rd(mem_rd), .d_wen(mem_wen), .d_load(mem_ld),
        .src1(hz.id_rs1_addr), .used1(hz.id_rs1_used),
        .src2(hz.id_rs2_addr), .used2(hz.id_rs2_used),
        .q_valid(wb_v), .q_rd(wb_rd), .q_wen(wb_wen), .q_load(wb_ld),
        .match1(wb_m1), .match2(wb_m2)
    );

    assign unused_wb = ^{wb_v, wb_rd, wb_wen, wb_ld};

    // Leaving FREEZE behaves like RUN in the same cycle so a held load-use is re-detected.
    assign run_like      = (state != LDSTALL);
    assign load_use      = ex_ld & (ex_m1 | ex_m2);
    assign redirect_take = ~hz.mem_busy & run_like & hz.ex_redirect;

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        pipe_en     = 1'b1;
        if (hz.mem_busy) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            pipe_en  = 1'b0;
        end else if (redirect_take) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (run_like && load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            fwd1_q  <= FWD_RF;
            fwd2_q  <= FWD_RF;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (hz.mem_busy)
                state <= FREEZE;
            else if (run_like && !hz.ex_redirect && load_use)
                state <= LDSTALL;
            else
                state <= RUN;

            if (id_ex_en) begin
                fwd1_q <= id_ex_flush ? FWD_RF : pick_fwd(ex_m1, mem_m1);
                fwd2_q <= id_ex_flush ? FWD_RF : pick_fwd(ex_m2, mem_m2);
            end

            if (!pc_en)
                stall_q <= stall_q + CNT_W'(1);
            if (redirect_take)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.pc_en       = pc_en;
    assign hz.if_id_en    = if_id_en;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_en    = id_ex_en;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.pipe_en     = pipe_en;
    assign hz.id_rs1_byp  = wb_m1;
    assign hz.id_rs2_byp  = wb_m2;
    assign hz.fwd_rs1_sel = fwd1_q;
    assign hz.fwd_rs2_sel = fwd2_q;
    assign hz.stall_cnt   = stall_q;
    assign hz.flush_cnt   = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios then random traffic,
// expectations from an in-flight instruction model, checked by an independent monitor.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int unsigned CNT_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.RA_W(5), .CNT_W(CNT_W)) hz ();
    hazard_ctrl #(.RA_W(5), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .hz(hz));

    typedef struct {
        bit pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, pipe_en, byp1, byp2;
        int fwd1, fwd2, sc, fc;
    } exp_t;

    typedef struct {
        bit v;
        int rd;
        bit w;
        bit ld;
    } instr_t;

    exp_t   expq[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     cyc         = 0;

    // Reference model: the instructions sitting in EX, MEM and WB plus counters.
    instr_t ex_i, mem_i, wb_i;
    bit     after_ld;
    int     m_fwd1, m_fwd2, m_sc, m_fc;
    int     modulus = 1 << CNT_W;

    function automatic bit hits(instr_t i, int src, bit used);
        return i.v && i.w && (i.rd != 0) && (i.rd == src) && used;
    endfunction

    function automatic int fwd_of(int src, bit used);
        if (hits(ex_i, src, used))  return 1;
        if (hits(mem_i, src, used)) return 2;
        return 0;
    endfunction

    task automatic drive_id(input int rs1, input bit u1, input int rs2, input bit u2,
                            input int rd, input bit wen, input bit ld,
                            input bit redir, input bit busy);
        hz.id_rs1_addr = 5'(rs1);
        hz.id_rs1_used = u1;
        hz.id_rs2_addr = 5'(rs2);
        hz.id_rs2_used = u2;
        hz.id_rd_addr  = 5'(rd);
        hz.id_rf_wen   = wen;
        hz.id_is_load  = ld;
        hz.ex_redirect = redir;
        hz.mem_busy    = busy;
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_i = '{default: 0}; mem_i = '{default: 0}; wb_i = '{default: 0};
        after_ld = 0; m_fwd1 = 0; m_fwd2 = 0; m_sc = 0; m_fc = 0;
        e = '{pc_en: 1, if_id_en: 1, if_id_flush: 0, id_ex_en: 1, id_ex_flush: 0,
              pipe_en: 1, byp1: 0, byp2: 0, fwd1: 0, fwd2: 0, sc: 0, fc: 0};
        expq.push_back(e);
    endtask

    task automatic step(input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit wen, input bit ld,
                        input bit redir, input bit busy);
        exp_t e;
        bit   lu;
        @(negedge clk);
        reset = 1'b0;
        drive_id(rs1, u1, rs2, u2, rd, wen, ld, redir, busy);
        e = '{pc_en: 1, if_id_en: 1, if_id_flush: 0, id_ex_en: 1, id_ex_flush: 0,
              pipe_en: 1, byp1: hits(wb_i, rs1, u1), byp2: hits(wb_i, rs2, u2),
              fwd1: m_fwd1, fwd2: m_fwd2, sc: m_sc, fc: m_fc};
        lu = ex_i.ld && (hits(ex_i, rs1, u1) || hits(ex_i, rs2, u2));
        if (busy) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.pipe_en = 0;
        end else if (!after_ld && redir) begin
            e.if_id_flush = 1; e.id_ex_flush = 1;
        end else if (!after_ld && lu) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_flush = 1;
        end
        expq.push_back(e);

        // Advance the model across the coming rising edge.
        if (!e.pc_en)       m_sc = (m_sc + 1) % modulus;
        if (e.if_id_flush)  m_fc = (m_fc + 1) % modulus;
        if (e.id_ex_en) begin
            m_fwd1 = e.id_ex_flush ? 0 : fwd_of(rs1, u1);
            m_fwd2 = e.id_ex_flush ? 0 : fwd_of(rs2, u2);
            wb_i   = mem_i;
            mem_i  = ex_i;
            ex_i   = e.id_ex_flush ? '{default: 0} : '{v: 1, rd: rd, w: wen, ld: ld};
        end
        after_ld = !busy && !e.pc_en;
        cyc++;
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, got, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                vectors++;
                chk("pc_en",       32'(hz.pc_en),       32'(e.pc_en));
                chk("if_id_en",    32'(hz.if_id_en),    32'(e.if_id_en));
                chk("if_id_flush", 32'(hz.if_id_flush), 32'(e.if_id_flush));
                chk("id_ex_en",    32'(hz.id_ex_en),    32'(e.id_ex_en));
                chk("id_ex_flush", 32'(hz.id_ex_flush), 32'(e.id_ex_flush));
                chk("pipe_en",     32'(hz.pipe_en),     32'(e.pipe_en));
                chk("id_rs1_byp",  32'(hz.id_rs1_byp),  32'(e.byp1));
                chk("id_rs2_byp",  32'(hz.id_rs2_byp),  32'(e.byp2));
                chk("fwd_rs1_sel", 32'(hz.fwd_rs1_sel), 32'(e.fwd1));
                chk("fwd_rs2_sel", 32'(hz.fwd_rs2_sel), 32'(e.fwd2));
                chk("stall_cnt",   32'(hz.stall_cnt),   32'(e.sc));
                chk("flush_cnt",   32'(hz.flush_cnt),   32'(e.fc));
            end
        end
    end

    initial begin : driver
        int rd, ld, wen;
        do_reset();

        // lw x5 ; add x6,x5,x1 back-to-back: one load-use stall, then FWD_WB
        step(1, 1, 0, 0, 5, 1, 1, 0, 0);
        step(5, 1, 1, 1, 6, 1, 0, 0, 0);
        step(5, 1, 1, 1, 6, 1, 0, 0, 0);
        nop(); nop(); nop();

        // addi x5,x0,7 ; add x6,x5,x5: both operands FWD_MEM, no stall
        do_reset();
        step(0, 1, 0, 0, 5, 1, 0, 0, 0);
        step(5, 1, 5, 1, 6, 1, 0, 0, 0);
        nop(); nop();

        // addi x5 ; nop ; nop ; add x6,x5,x0: ID bypass from WB
        do_reset();
        step(0, 1, 0, 0, 5, 1, 0, 0, 0);
        nop(); nop();
        step(5, 1, 0, 1, 6, 1, 0, 0, 0);
        nop();

        // taken beq with lw-use pair behind it: flush only
        do_reset();
        step(1, 1, 2, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 5, 1, 1, 1, 0);
        step(5, 1, 1, 1, 6, 1, 0, 0, 0);
        nop(); nop();

        // mem_busy for 3 cycles during a lw-use stall, then the stall completes
        do_reset();
        step(1, 1, 0, 0, 5, 1, 1, 0, 0);
        repeat (3) step(5, 1, 1, 1, 6, 1, 0, 0, 1);
        step(5, 1, 1, 1, 6, 1, 0, 0, 0);
        step(5, 1, 1, 1, 6, 1, 0, 0, 0);
        nop(); nop(); nop();

        // x0 writes never forward; then reset landing in LDSTALL
        do_reset();
        step(0, 1, 0, 0, 0, 1, 1, 0, 0);
        step(0, 1, 0, 1, 6, 1, 0, 0, 0);
        nop();
        step(1, 1, 0, 0, 5, 1, 1, 0, 0);
        step(5, 1, 1, 1, 6, 1, 0, 0, 0);
        do_reset();
        step(5, 1, 1, 1, 6, 1, 0, 0, 0);
        nop();

        // random traffic over a small register set to provoke frequent hazards
        for (int i = 0; i < 2000; i++) begin
            ld  = ($urandom_range(0, 99) < 30) ? 1 : 0;
            wen = ld ? 1 : int'($urandom_range(0, 1));
            rd  = $urandom_range(0, 3);
            step($urandom_range(0, 3), bit'($urandom_range(0, 1)),
                 $urandom_range(0, 3), bit'($urandom_range(0, 1)),
                 rd, bit'(wen), bit'(ld),
                 ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 12));
            if ($urandom_range(0, 299) == 0)
                do_reset();
        end

        repeat (3) @(negedge clk);
        #4;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain left=%0d expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
